// File: rtl/macro_unsumsqr.sv
// ---------------------------------------------------------------------------
// macro_unsumsqr
//
// Purpose:
//   Reverses the sum-of-squares datapath. It accepts down_data = x*x + OFFSET
//   and returns up_data = floor(sqrt(down_data - OFFSET)). The root is found
//   with the iterative digit-by-digit integer square root, one result bit per
//   clock. It accepts one operand at a time, with a valid/ready handshake on
//   both the input and the output side.
//
// Parameters:
//   WIDTH   - width of down_data. Must be even. The root is WIDTH/2 bits wide.
//   OFFSET  - constant removed before the root is taken. Must be < 2**WIDTH.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous reset, active low
//   in_valid   in   down_data is valid
//   in_ready   out  block is idle and can accept an operand
//   down_data  in   operand x*x + OFFSET
//   out_valid  out  result is valid
//   out_ready  in   consumer takes the result
//   up_data    out  floor square root of (down_data - OFFSET)
//   underflow  out  the operand was smaller than OFFSET
//   exact      out  present only when MACRO_UNSUMSQR_EXACT_EN is defined.
//                   It is high when down_data - OFFSET is a perfect square.
//
// Build option:
//   MACRO_UNSUMSQR_EXACT_EN - adds the exact output and the compare of the
//                             final remainder against zero.
// ---------------------------------------------------------------------------
module macro_unsumsqr #(
    parameter int WIDTH  = 32,
    parameter int OFFSET = 144
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     down_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH/2-1:0]   up_data,
    output logic                 underflow
`ifdef MACRO_UNSUMSQR_EXACT_EN
    ,
    output logic                 exact
`endif
);

    localparam int HALF = WIDTH / 2;
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

    localparam logic [WIDTH-1:0] OFFSET_W   = WIDTH'(OFFSET);
    localparam logic [CW-1:0]    LAST_COUNT = CW'(HALF - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   radicand;
    logic [HALF+1:0]    rem;
    logic [HALF-1:0]    root;
    logic [CW-1:0]      count;

    logic [HALF+3:0]    rem_shift;
    logic [HALF+3:0]    trial;
    logic               take;
    logic [HALF+1:0]    rem_next;
    logic [HALF-1:0]    root_next;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // This block computes one step of the square root. It brings down the
    // next two bits of the radicand and tries to subtract {root, 01}. The
    // compare is done two bits wider than the remainder register, so the
    // shifted value is never cut off. Only the true remainder is stored, and
    // it always fits in HALF+2 bits.
    always_comb begin
        rem_shift = {rem, radicand[WIDTH-1 -: 2]};
        trial     = {2'b00, root, 2'b01};
        take      = (rem_shift >= trial);
        if (take) begin
            rem_next = rem_shift[HALF+1:0] - trial[HALF+1:0];
        end else begin
            rem_next = rem_shift[HALF+1:0];
        end
        root_next = HALF'({root, take});
    end

    // This is the control and datapath register block. The operands are
    // handled one at a time. While the block is busy, in_ready is low, so
    // in_valid has no effect. The result registers keep their value after
    // the block retires and goes back to IDLE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            radicand  <= '0;
            rem       <= '0;
            root      <= '0;
            count     <= '0;
            up_data   <= '0;
            underflow <= 1'b0;
`ifdef MACRO_UNSUMSQR_EXACT_EN
            exact     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (down_data < OFFSET_W) begin
                            up_data   <= '0;
                            underflow <= 1'b1;
`ifdef MACRO_UNSUMSQR_EXACT_EN
                            exact     <= 1'b0;
`endif
                            state     <= DONE;
                        end else begin
                            radicand  <= down_data - OFFSET_W;
                            rem       <= '0;
                            root      <= '0;
                            count     <= LAST_COUNT;
                            underflow <= 1'b0;
                            state     <= CALC;
                        end
                    end
                end
                CALC: begin
                    radicand <= radicand << 2;
                    rem      <= rem_next;
                    root     <= root_next;
                    if (count == '0) begin
                        up_data <= root_next;
`ifdef MACRO_UNSUMSQR_EXACT_EN
                        exact   <= (rem_next == '0);
`endif
                        state   <= DONE;
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
